mips32_prog_loader: RTL and testbench
=====================================

# mips32_prog_loader

Front-end loader that sits upstream of the pipelined MIPS32 core. It accepts a program as a stream of 32-bit words over a valid/ready handshake and writes them into the core's unified memory starting at a commanded base address. It holds the core halted while loading, then releases it with PC set to the base address and the branch flag cleared. This replaces hierarchical pokes into the core's memory and state with a synthesizable boot path.

## Interface
- ADDR_W, 10, memory word-address width; the address space is 2^ADDR_W words.
- clk1  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; forces every register to its reset value immediately.
- cmd_start  in  1  single-cycle pulse that begins a load; accepted only in IDLE, RUN or ERROR.
- cmd_base  in  ADDR_W  first word address; sampled with cmd_start.
- cmd_len  in  ADDR_W+1  number of program words (0..2^ADDR_W); sampled with cmd_start.
- in_valid  in  1  stream word valid.
- in_data  in  32  stream word.
- in_ready  out  1  loader can accept a word.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory write address.
- mem_wdata  out  32  memory write data.
- core_hold  out  1  high keeps the core halted (drives the core's HALTED flag).
- core_pc_load  out  1  one-cycle pulse: core loads PC from core_pc and clears its branch-taken flag.
- core_pc  out  32  zero-extended start address.
- busy  out  1  load in progress.
- done  out  1  core running a loaded program.
- err  out  1  load failed.

## Operation
- States: IDLE, LOAD, CHECK (only with the macro), RELEASE, RUN, ERROR.
- IDLE: core_hold=1, in_ready=0. On cmd_start: latch base and len, clear word index and running sum, then go to LOAD (or past LOAD if len=0, see below).
- LOAD: in_ready=1, busy=1. Each handshake (in_valid & in_ready) writes in_data to address (base+index) mod 2^ADDR_W, increments the index, and adds in_data to the running sum mod 2^32. When the handshake carrying word len-1 completes, go to CHECK if enabled, otherwise to RELEASE.
- A len of 0 skips LOAD and goes directly to CHECK or RELEASE.
- RELEASE: lasts one cycle. core_pc_load=1 and core_pc={0,base}. Next state is RUN.
- RUN: core_hold=0, done=1. A cmd_start here restarts the load; core_hold returns to 1 on the next cycle.
- ERROR: err=1, core_hold=1. The block leaves ERROR only on cmd_start or reset.
- cmd_start asserted during LOAD, CHECK or RELEASE is ignored.
- in_valid outside LOAD/CHECK is ignored; no write occurs.
- Address wraps past 2^ADDR_W-1 to 0. When len=2^ADDR_W, every word is written exactly once.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, core_pc_load=0, core_pc=0, busy=0, done=0, err=0. State returns to IDLE.
- cmd_start in cycle N puts the block in LOAD in cycle N+1, with in_ready=1 in N+1.
- Write outputs are registered. A handshake in cycle N produces mem_we=1 with the corresponding address and data in cycle N+1. mem_we is 0 in every other cycle.
- Sustained throughput is one word per cycle, and in_ready stays high across back-to-back handshakes.
- The last handshake in cycle N gives RELEASE in N+1 (or CHECK in N+1 with the macro) and core_hold=0 in N+2 (or N+3 with the macro).
- If reset asserts mid-load, the write in flight is dropped, the memory keeps any partial contents, and core_hold=1.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - CHECK state is present with in_ready=1.
  - The block accepts one extra word, which is not written to memory.
  - If the word equals the running sum mod 2^32, go to RELEASE; otherwise go to ERROR.
  - With len=0, the expected checksum is 0.
- LOADER_CHECKSUM_EN undefined:
  - No CHECK state exists.
  - err is tied to 0, and ERROR is unreachable.

## Test plan
- Reset then idle 10 cycles -> core_hold=1, in_ready=0, mem_we never asserts, all other outputs 0.
- cmd_base=0, cmd_len=7, stream 28010078, 0ce77800, 20220000, 0ce77800, 2842002d, 0ce77800, 24220001 back-to-back (checksum word = sum if the macro is on) -> addresses 0..6 are written one per cycle, then a single core_pc_load with core_pc=0, then core_hold=0. With a core attached and MEM[120]=85, MEM[121]=130.
- cmd_base=2^ADDR_W-2, cmd_len=4, words A,B,C,D -> writes land at addresses 1022, 1023, 0, 1.
- With the macro: words 1,2,3 followed by checksum 6 -> done=1. The same words followed by checksum 7 -> err=1, core_hold=1, no core_pc_load pulse.
- Toggle in_valid every other cycle, pulse cmd_start mid-LOAD, then assert reset after word 2 of 5 -> the extra cmd_start is ignored, stalls are honoured, and reset immediately returns all outputs to their reset values.
- cmd_len=0 -> RELEASE occurs 1 cycle after cmd_start (2 cycles with the macro and checksum 0), with zero memory writes.

Source files
------------

// File: rtl/mips32_prog_loader_if.sv
// Boot-path bundle between a program source, the MIPS32 unified memory and the core's
// run-control inputs; the loader takes the slave view, the stream/command side the master view.
interface mips32_prog_loader_if #(
    parameter int ADDR_W = 10
);
    logic              cmd_start;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W:0]   cmd_len;

    // Stream handshake: a word moves on every rising edge where in_valid and in_ready are both 1;
    // in_data must hold steady while in_valid waits, and in_ready never depends on in_valid.
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_ready;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    logic              core_hold;
    logic              core_pc_load;
    logic [31:0]       core_pc;

    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output cmd_start, cmd_base, cmd_len, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  core_hold, core_pc_load, core_pc, busy, done, err
    );

    modport slave (
        input  cmd_start, cmd_base, cmd_len, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output core_hold, core_pc_load, core_pc, busy, done, err
    );
endinterface

// File: rtl/mips32_prog_loader.sv
// Streams a program into the MIPS32 unified memory, holding the core until it is released at the
// base address. Define LOADER_CHECKSUM_EN to require a trailing checksum word before release.
module mips32_prog_loader #(
    parameter int ADDR_W = 10
) (
    input  logic                clk1,
    input  logic                reset,
    mips32_prog_loader_if.slave bus,
    output logic [2:0]          dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK   = 3'd2,
`endif
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   remaining;
    logic              hs;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       sum_q;
`else
    assign bus.err = 1'b0;
`endif

    assign hs        = bus.in_valid & bus.in_ready;
    assign dbg_state = state;

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            base_q           <= '0;
            wr_ptr           <= '0;
            remaining        <= '0;
            bus.in_ready     <= 1'b0;
            bus.mem_we       <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_wdata    <= '0;
            bus.core_hold    <= 1'b1;
            bus.core_pc_load <= 1'b0;
            bus.core_pc      <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q            <= '0;
            bus.err          <= 1'b0;
`endif
        end else begin
            bus.mem_we       <= 1'b0;
            bus.core_pc_load <= 1'b0;
            case (state)
                S_IDLE, S_RUN, S_ERROR: begin
                    if (bus.cmd_start) begin
                        base_q        <= bus.cmd_base;
                        wr_ptr        <= bus.cmd_base;
                        remaining     <= bus.cmd_len;
                        bus.core_hold <= 1'b1;
                        bus.done      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        sum_q         <= '0;
                        bus.err       <= 1'b0;
`endif
                        if (bus.cmd_len == '0) begin
`ifdef LOADER_CHECKSUM_EN
                            // An empty program still owes a checksum word (expected 0).
                            state        <= S_CHECK;
                            bus.in_ready <= 1'b1;
                            bus.busy     <= 1'b1;
`else
                            state            <= S_RELEASE;
                            bus.core_pc_load <= 1'b1;
                            bus.core_pc      <= {{(32-ADDR_W){1'b0}}, bus.cmd_base};
`endif
                        end else begin
                            state        <= S_LOAD;
                            bus.in_ready <= 1'b1;
                            bus.busy     <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (hs) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= wr_ptr;
                        bus.mem_wdata <= bus.in_data;
                        wr_ptr        <= wr_ptr + ADDR_W'(1);
                        remaining     <= remaining - (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
                        sum_q         <= sum_q + bus.in_data;
`endif
                        if (remaining == (ADDR_W+1)'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                            state <= S_CHECK;
`else
                            state            <= S_RELEASE;
                            bus.in_ready     <= 1'b0;
                            bus.busy         <= 1'b0;
                            bus.core_pc_load <= 1'b1;
                            bus.core_pc      <= {{(32-ADDR_W){1'b0}}, base_q};
`endif
                        end
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (hs) begin
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b0;
                        if (bus.in_data == sum_q) begin
                            state            <= S_RELEASE;
                            bus.core_pc_load <= 1'b1;
                            bus.core_pc      <= {{(32-ADDR_W){1'b0}}, base_q};
                        end else begin
                            state   <= S_ERROR;
                            bus.err <= 1'b1;
                        end
                    end
                end
`endif

                S_RELEASE: begin
                    state         <= S_RUN;
                    bus.core_hold <= 1'b0;
                    bus.done      <= 1'b1;
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader: table of load commands plus hand-written corner sequences.
module tb_mips32_prog_loader;
    localparam int ADDR_W = 10;
    localparam int W      = ADDR_W + 32;

    logic       clk1  = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] dbg_state;

    mips32_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    mips32_prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk1      (clk1),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk1 = ~clk1;

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    // ---------------- write / release monitor ----------------
    logic [W-1:0] obs_q[$];
    int           obs_cyc[$];
    int           pcl_cnt = 0;

    always @(negedge clk1) begin
        if (bus.mem_we) begin
            obs_q.push_back({bus.mem_addr, bus.mem_wdata});
            obs_cyc.push_back(cyc);
        end
        if (bus.core_pc_load) pcl_cnt++;
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           total = 0;
    int           bad   = 0;
    int           rd_idx = 0;
    logic [31:0]  prog[1024];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_writes(input string name, input int span);
        int n;
        int first;
        n     = obs_q.size() - rd_idx;
        first = rd_idx;
        chk({name, "_nwrites"}, 64'(n), 64'(exp_q.size()));
        while (exp_q.size() > 0 && rd_idx < obs_q.size()) begin
            chk({name, "_write"}, 64'(obs_q[rd_idx]), 64'(exp_q.pop_front()));
            rd_idx++;
        end
        if (span > 0 && n > 1)
            chk({name, "_b2b"}, 64'(obs_cyc[obs_q.size()-1] - obs_cyc[first]), 64'(span));
        exp_q.delete();
        rd_idx = obs_q.size();
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk1);
        #1 reset = 1'b0;
    endtask

    task automatic cmd(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
        bus.cmd_start = 1'b1;
        bus.cmd_base  = base;
        bus.cmd_len   = len;
        @(posedge clk1);
        #1 bus.cmd_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk1);
            #1 t++;
        end
        if (t >= 50) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready got 0 want 1");
        end
        @(posedge clk1);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic run_load(input string name, input logic [ADDR_W-1:0] base,
                            input logic [ADDR_W:0] len);
        logic [31:0]       sum;
        logic [ADDR_W-1:0] a;
        int                pcl0;
        sum    = '0;
        pcl0   = pcl_cnt;
        rd_idx = obs_q.size();
        cmd(base, len);
`ifdef LOADER_CHECKSUM_EN
        chk({name, "_ready"}, 64'(bus.in_ready), 64'(1));
        chk({name, "_busy"}, 64'(bus.busy), 64'(1));
`else
        if (len != 0) begin
            chk({name, "_ready"}, 64'(bus.in_ready), 64'(1));
            chk({name, "_busy"}, 64'(bus.busy), 64'(1));
        end
`endif
        for (int i = 0; i < int'(len); i++) begin
            a = base + ADDR_W'(i);
            exp_q.push_back({a, prog[i]});
            sum = sum + prog[i];
            send_word(prog[i]);
        end
`ifdef LOADER_CHECKSUM_EN
        send_word(sum);
`endif
        chk({name, "_pc_load"}, 64'(bus.core_pc_load), 64'(1));
        chk({name, "_pc"}, 64'(bus.core_pc), 64'({22'b0, base}));
        chk({name, "_hold_rel"}, 64'(bus.core_hold), 64'(1));
        chk({name, "_ready_rel"}, 64'(bus.in_ready), 64'(0));
        @(posedge clk1);
        #1;
        chk({name, "_hold_run"}, 64'(bus.core_hold), 64'(0));
        chk({name, "_done"}, 64'(bus.done), 64'(1));
        chk({name, "_pc_load_off"}, 64'(bus.core_pc_load), 64'(0));
        chk({name, "_pcl_count"}, 64'(pcl_cnt - pcl0), 64'(1));
        check_writes(name, int'(len) - 1);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_ready"}, 64'(bus.in_ready), 64'(0));
        chk({name, "_we"}, 64'(bus.mem_we), 64'(0));
        chk({name, "_addr"}, 64'(bus.mem_addr), 64'(0));
        chk({name, "_wdata"}, 64'(bus.mem_wdata), 64'(0));
        chk({name, "_hold"}, 64'(bus.core_hold), 64'(1));
        chk({name, "_pc_load"}, 64'(bus.core_pc_load), 64'(0));
        chk({name, "_pc"}, 64'(bus.core_pc), 64'(0));
        chk({name, "_busy"}, 64'(bus.busy), 64'(0));
        chk({name, "_done"}, 64'(bus.done), 64'(0));
        chk({name, "_err"}, 64'(bus.err), 64'(0));
        chk({name, "_state"}, 64'(dbg_state), 64'(0));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W:0]   len;
        logic [31:0]       w0;
        logic [31:0]       step;
        logic [ADDR_W-1:0] exp_last;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [W-1:0] last_w;
        logic [31:0]  sum;
        int           pcl0;

        bus.cmd_start = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_len   = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;

        vecs[0] = '{base: 10'd1022, len: 11'd4,    w0: 32'h0000000a, step: 32'd1,         exp_last: 10'd1};
        vecs[1] = '{base: 10'd5,    len: 11'd1,    w0: 32'hdeadbeef, step: 32'd0,         exp_last: 10'd5};
        vecs[2] = '{base: 10'd100,  len: 11'd3,    w0: 32'd1,        step: 32'd1,         exp_last: 10'd102};
        vecs[3] = '{base: 10'd0,    len: 11'd0,    w0: 32'd0,        step: 32'd0,         exp_last: 10'd0};
        vecs[4] = '{base: 10'd1023, len: 11'd2,    w0: 32'h80000000, step: 32'h80000000, exp_last: 10'd0};
        vecs[5] = '{base: 10'd512,  len: 11'd1024, w0: 32'd0,        step: 32'd3,         exp_last: 10'd511};

        #1 do_reset();

        // Reset, then idle with nothing commanded.
        check_reset_outputs("reset");
        repeat (10) @(posedge clk1);
        #1;
        check_reset_outputs("idle");
        chk("idle_nwrites", 64'(obs_q.size()), 64'(0));

        // Small MIPS program at address 0.
        prog[0] = 32'h28010078; prog[1] = 32'h0ce77800; prog[2] = 32'h20220000;
        prog[3] = 32'h0ce77800; prog[4] = 32'h2842002d; prog[5] = 32'h0ce77800;
        prog[6] = 32'h24220001;
        run_load("prog7", 10'd0, 11'd7);

        // Table of loads, each restarted from RUN.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < int'(vecs[v].len); i++)
                prog[i] = vecs[v].w0 + vecs[v].step * 32'(i);
            run_load($sformatf("vec%0d", v), vecs[v].base, vecs[v].len);
            if (vecs[v].len != 0) begin
                last_w = obs_q[obs_q.size()-1];
                chk($sformatf("vec%0d_last_addr", v), 64'(last_w[W-1:32]), 64'(vecs[v].exp_last));
            end
        end

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: words 1,2,3 followed by 7 instead of 6.
        pcl0   = pcl_cnt;
        rd_idx = obs_q.size();
        cmd(10'd50, 11'd3);
        sum = 32'd0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({10'd50 + 10'(i), 32'(i + 1)});
            sum = sum + 32'(i + 1);
            send_word(32'(i + 1));
        end
        send_word(sum + 32'd1);
        repeat (3) @(posedge clk1);
        #1;
        chk("badck_err", 64'(bus.err), 64'(1));
        chk("badck_hold", 64'(bus.core_hold), 64'(1));
        chk("badck_done", 64'(bus.done), 64'(0));
        chk("badck_pcl", 64'(pcl_cnt - pcl0), 64'(0));
        check_writes("badck", 0);
`endif

        // Stalled load with an ignored cmd_start, then reset after the second word.
        for (int i = 0; i < 5; i++) prog[i] = 32'h11110000 + 32'(i);
        rd_idx = obs_q.size();
        cmd(10'd200, 11'd5);
        exp_q.push_back({10'd200, prog[0]});
        send_word(prog[0]);
        bus.cmd_start = 1'b1;
        bus.cmd_base  = 10'd300;
        bus.cmd_len   = 11'd2;
        @(posedge clk1);
        #1 bus.cmd_start = 1'b0;
        chk("stall_ready", 64'(bus.in_ready), 64'(1));
        chk("stall_we", 64'(bus.mem_we), 64'(0));
        chk("stall_busy", 64'(bus.busy), 64'(1));
        exp_q.push_back({10'd201, prog[1]});
        send_word(prog[1]);
        chk("stall_addr1", 64'(bus.mem_addr), 64'(201));
        bus.in_valid = 1'b1;
        bus.in_data  = prog[2];
        #6 reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk1);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk1);
        #1;
        check_reset_outputs("postreset");
        check_writes("stall", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
